// File: rtl/decoder_bp.sv
// decoder_bp: RV32I decode/dispatch stage with a valid/ready fetch handshake
// and a table of 2-bit counters predicting conditional branches.
module decoder_bp #(
  parameter int          ROB_W       = 3,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] HALT_INST   = 32'hff9ff06f
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst,
  output logic [4:0]       reg_id1,
  output logic [4:0]       reg_id2,
  input  logic [31:0]      reg_val1,
  input  logic [31:0]      reg_val2,
  input  logic             reg_has_dep1,
  input  logic             reg_has_dep2,
  input  logic [ROB_W-1:0] reg_dep1,
  input  logic [ROB_W-1:0] reg_dep2,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_free_id,
  output logic             rob_valid,
  output logic [1:0]       rob_type,
  output logic [4:0]       rob_rd,
  output logic [31:0]      rob_value,
  output logic [31:0]      rob_pc,
  output logic [31:0]      rob_alt_addr,
  output logic             rob_ready,
  output logic             rob_pred_taken,
  input  logic             rs_full,
  output logic             rs_valid,
  output logic [5:0]       rs_type,
  input  logic             lsb_full,
  output logic             lsb_valid,
  output logic [3:0]       lsb_type,
  output logic [11:0]      lsb_offset,
  output logic [31:0]      op_r1,
  output logic [31:0]      op_r2,
  output logic             op_has_dep1,
  output logic             op_has_dep2,
  output logic [ROB_W-1:0] op_dep1,
  output logic [ROB_W-1:0] op_dep2,
  output logic [ROB_W-1:0] op_rob_id,
  input  logic             bht_upd_valid,
  input  logic [31:0]      bht_upd_pc,
  input  logic             bht_upd_taken,
  output logic             if_redirect,
  output logic [31:0]      if_redirect_addr
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [1:0] T_RG = 2'd0;
  localparam logic [1:0] T_ST = 2'd1;
  localparam logic [1:0] T_BR = 2'd2;
  localparam logic [1:0] T_EX = 2'd3;

  logic [6:0] opc;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_load, is_store, is_opi, is_op;
  logic is_known, is_halt, is_mul;
  logic need_rs, need_lsb, use1, use2, writes_rd;
  logic accept;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BR);
  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign is_opi   = (opc == OPC_OPI);
  assign is_op    = (opc == OPC_OP);
  assign is_halt  = (inst == HALT_INST);
  assign is_mul   = is_op && (inst[31:25] == 7'b0000001);

  assign is_known = is_lui | is_auipc | is_jal | is_jalr | is_br
                  | is_load | is_store | is_opi | is_op;

  assign need_rs   = is_br | is_op | is_opi;
  assign need_lsb  = is_load | is_store;
  assign use1      = is_op | is_opi | is_br | is_load | is_store | is_jalr;
  assign use2      = is_op | is_br | is_store;
  assign writes_rd = is_lui | is_auipc | is_jal | is_jalr
                   | is_load | is_opi | is_op;

  assign reg_id1 = inst[19:15];
  assign reg_id2 = inst[24:20];

  assign inst_ready = !flush && !rob_full
                    && !(need_rs && rs_full)
                    && !(need_lsb && lsb_full)
                    && !(is_jalr && reg_has_dep1);

  assign accept = inst_valid && inst_ready && rdy_in;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // Branch history table; lookups see the value before this cycle's update
  logic [1:0]     bht_q [BHT_ENTRIES];
  logic [IDX-1:0] look_idx;
  logic [IDX-1:0] upd_idx;
  logic [1:0]     upd_cur;
  logic           pred;

  assign look_idx = inst_addr[IDX+1:2];
  assign upd_idx  = bht_upd_pc[IDX+1:2];
  assign upd_cur  = bht_q[upd_idx];
  assign pred     = bht_q[look_idx][1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (rdy_in && bht_upd_valid) begin
      if (bht_upd_taken) begin
        if (upd_cur != 2'b11) bht_q[upd_idx] <= upd_cur + 2'd1;
      end else begin
        if (upd_cur != 2'b00) bht_q[upd_idx] <= upd_cur - 2'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{inst_addr[1:0], bht_upd_pc[31:IDX+2],
                         bht_upd_pc[1:0]};

  logic [1:0]  type_d;
  logic [4:0]  rd_d;
  logic [31:0] value_d, alt_d, raddr_d, r2_d;
  logic        ready_d, pred_d, redir_d;
  logic [5:0]  rs_type_d;
  logic [3:0]  lsb_type_d;
  logic [11:0] lsb_off_d;

  always_comb begin
    type_d     = T_RG;
    rd_d       = writes_rd ? inst[11:7] : 5'd0;
    value_d    = 32'd0;
    alt_d      = 32'd0;
    raddr_d    = 32'd0;
    redir_d    = 1'b0;
    ready_d    = is_lui | is_auipc | is_jal | is_jalr | !is_known;
    pred_d     = is_br & pred;
    r2_d       = reg_val2;
    rs_type_d  = {is_mul, is_br, inst[30], f3};
    lsb_type_d = {is_store, f3};
    lsb_off_d  = is_store ? imm_s[11:0] : imm_i[11:0];

    if (is_halt)       type_d = T_EX;
    else if (is_store) type_d = T_ST;
    else if (is_br)    type_d = T_BR;
    else if (!is_known) type_d = T_EX;

    unique case (1'b1)
      is_lui:   value_d = imm_u;
      is_auipc: value_d = inst_addr + imm_u;
      is_jal: begin
        value_d = inst_addr + 32'd4;
        redir_d = 1'b1;
        raddr_d = inst_addr + imm_j;
      end
      is_jalr: begin
        value_d = inst_addr + 32'd4;
        redir_d = 1'b1;
        raddr_d = (reg_val1 + imm_i) & ~32'd1;
      end
      is_br: begin
        redir_d = pred;
        raddr_d = inst_addr + imm_b;
        alt_d   = pred ? inst_addr + 32'd4 : inst_addr + imm_b;
      end
      is_opi: begin
        if (f3 == 3'b001 || f3 == 3'b101) r2_d = {27'd0, inst[24:20]};
        else r2_d = imm_i;
      end
      default: ;
    endcase
  end

  logic             rob_valid_q, rs_valid_q, lsb_valid_q, redir_q;
  logic [1:0]       type_q;
  logic [4:0]       rd_q;
  logic [31:0]      value_q, pc_q, alt_q, raddr_q, r1_q, r2_q;
  logic             ready_q, pred_q, hd1_q, hd2_q;
  logic [5:0]       rs_type_q;
  logic [3:0]       lsb_type_q;
  logic [11:0]      lsb_off_q;
  logic [ROB_W-1:0] dep1_q, dep2_q, rob_id_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_valid_q <= 1'b0;
      rs_valid_q  <= 1'b0;
      lsb_valid_q <= 1'b0;
      redir_q     <= 1'b0;
      type_q      <= '0;
      rd_q        <= '0;
      value_q     <= '0;
      pc_q        <= '0;
      alt_q       <= '0;
      raddr_q     <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      ready_q     <= 1'b0;
      pred_q      <= 1'b0;
      hd1_q       <= 1'b0;
      hd2_q       <= 1'b0;
      rs_type_q   <= '0;
      lsb_type_q  <= '0;
      lsb_off_q   <= '0;
      dep1_q      <= '0;
      dep2_q      <= '0;
      rob_id_q    <= '0;
    end else if (rdy_in) begin
      rob_valid_q <= accept;
      rs_valid_q  <= accept && need_rs;
      lsb_valid_q <= accept && need_lsb;
      redir_q     <= accept && redir_d;
      if (accept) begin
        type_q     <= type_d;
        rd_q       <= rd_d;
        value_q    <= value_d;
        pc_q       <= inst_addr;
        alt_q      <= alt_d;
        raddr_q    <= raddr_d;
        r1_q       <= reg_val1;
        r2_q       <= r2_d;
        ready_q    <= ready_d;
        pred_q     <= pred_d;
        hd1_q      <= use1 && reg_has_dep1;
        hd2_q      <= use2 && reg_has_dep2;
        rs_type_q  <= rs_type_d;
        lsb_type_q <= lsb_type_d;
        lsb_off_q  <= lsb_off_d;
        dep1_q     <= reg_dep1;
        dep2_q     <= reg_dep2;
        rob_id_q   <= rob_free_id;
      end
    end
  end

  assign rob_valid        = rob_valid_q;
  assign rob_type         = type_q;
  assign rob_rd           = rd_q;
  assign rob_value        = value_q;
  assign rob_pc           = pc_q;
  assign rob_alt_addr     = alt_q;
  assign rob_ready        = ready_q;
  assign rob_pred_taken   = pred_q;
  assign rs_valid         = rs_valid_q;
  assign rs_type          = rs_type_q;
  assign lsb_valid        = lsb_valid_q;
  assign lsb_type         = lsb_type_q;
  assign lsb_offset       = lsb_off_q;
  assign op_r1            = r1_q;
  assign op_r2            = r2_q;
  assign op_has_dep1      = hd1_q;
  assign op_has_dep2      = hd2_q;
  assign op_dep1          = dep1_q;
  assign op_dep2          = dep2_q;
  assign op_rob_id        = rob_id_q;
  assign if_redirect      = redir_q;
  assign if_redirect_addr = raddr_q;

endmodule

// File: tb/tb_decoder_bp.sv
// tb_decoder_bp: directed plan plus randomized traffic against a
// scoreboard fed by a behavioural decode/BHT model.
module tb_decoder_bp;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, inst_valid, inst_ready;
  logic [31:0] inst_addr, inst;
  logic [4:0]  reg_id1, reg_id2;
  logic [31:0] reg_val1, reg_val2;
  logic        reg_has_dep1, reg_has_dep2;
  logic [2:0]  reg_dep1, reg_dep2;
  logic        rob_full;
  logic [2:0]  rob_free_id;
  logic        rob_valid;
  logic [1:0]  rob_type;
  logic [4:0]  rob_rd;
  logic [31:0] rob_value, rob_pc, rob_alt_addr;
  logic        rob_ready, rob_pred_taken;
  logic        rs_full, rs_valid;
  logic [5:0]  rs_type;
  logic        lsb_full, lsb_valid;
  logic [3:0]  lsb_type;
  logic [11:0] lsb_offset;
  logic [31:0] op_r1, op_r2;
  logic        op_has_dep1, op_has_dep2;
  logic [2:0]  op_dep1, op_dep2, op_rob_id;
  logic        bht_upd_valid, bht_upd_taken;
  logic [31:0] bht_upd_pc;
  logic        if_redirect;
  logic [31:0] if_redirect_addr;

  always #5 clk_in = ~clk_in;

  decoder_bp dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_addr(inst_addr), .inst(inst),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_val1(reg_val1), .reg_val2(reg_val2),
    .reg_has_dep1(reg_has_dep1), .reg_has_dep2(reg_has_dep2),
    .reg_dep1(reg_dep1), .reg_dep2(reg_dep2),
    .rob_full(rob_full), .rob_free_id(rob_free_id),
    .rob_valid(rob_valid), .rob_type(rob_type), .rob_rd(rob_rd),
    .rob_value(rob_value), .rob_pc(rob_pc), .rob_alt_addr(rob_alt_addr),
    .rob_ready(rob_ready), .rob_pred_taken(rob_pred_taken),
    .rs_full(rs_full), .rs_valid(rs_valid), .rs_type(rs_type),
    .lsb_full(lsb_full), .lsb_valid(lsb_valid), .lsb_type(lsb_type),
    .lsb_offset(lsb_offset),
    .op_r1(op_r1), .op_r2(op_r2),
    .op_has_dep1(op_has_dep1), .op_has_dep2(op_has_dep2),
    .op_dep1(op_dep1), .op_dep2(op_dep2), .op_rob_id(op_rob_id),
    .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc),
    .bht_upd_taken(bht_upd_taken),
    .if_redirect(if_redirect), .if_redirect_addr(if_redirect_addr)
  );

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_JAL = 7'b1101111, O_JALR  = 7'b1100111;
  localparam logic [6:0] O_BR  = 7'b1100011, O_LD    = 7'b0000011;
  localparam logic [6:0] O_ST  = 7'b0100011, O_OPI   = 7'b0010011;
  localparam logic [6:0] O_OP  = 7'b0110011;

  typedef struct {
    int          tag;
    logic [31:0] pc, value, alt, raddr, r1, r2;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [5:0]  rst;
    logic [3:0]  lt;
    logic [11:0] lo;
    logic [2:0]  d1, d2, rid;
    bit care_rd, care_val, is_br, pred, ready, rsv, lsbv;
    bit u1, care_r2, hd1, hd2, redir;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   ctr[64];
  int   act = 0;
  bit   fresh = 0;
  bit   last_acc = 0;
  int   passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, a, e);
  endtask

  task automatic fail_one(input string nm);
    total++;
    $display("FAIL %s: got 0, expected 1", nm);
  endtask

  function automatic logic [31:0] imm_i(input logic [31:0] x);
    return $signed(x) >>> 20;
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] x);
    return (imm_i(x) & ~32'h1f) | ((x >> 7) & 32'h1f);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] x);
    logic [31:0] r;
    r = x[31] ? 32'hFFFFF000 : 32'h0;
    r = r + (((x >> 7) & 32'h1) << 11) + (((x >> 25) & 32'h3f) << 5)
          + (((x >> 8) & 32'hf) << 1);
    return r;
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] x);
    logic [31:0] r;
    r = x[31] ? 32'hFFF00000 : 32'h0;
    r = r + (((x >> 12) & 32'hff) << 12) + (((x >> 20) & 32'h1) << 11)
          + (((x >> 21) & 32'h3ff) << 1);
    return r;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    logic [2:0] f3;
    bit nrs, nlsb, rexp, known, mul;
    exp_t e;
    int ix;
    op    = inst[6:0];
    f3    = inst[14:12];
    known = op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST,
                       O_OPI, O_OP};
    nrs   = op inside {O_BR, O_OP, O_OPI};
    nlsb  = op inside {O_LD, O_ST};
    rexp  = !flush && !rob_full && !(nrs && rs_full)
            && !(nlsb && lsb_full) && !(op == O_JALR && reg_has_dep1);
    chk("inst_ready", 32'(inst_ready), 32'(rexp));
    chk("reg_id1", 32'(reg_id1), (inst >> 15) & 32'h1f);
    chk("reg_id2", 32'(reg_id2), (inst >> 20) & 32'h1f);
    last_acc = 0;
    if (rst_in) begin
      foreach (ctr[i]) ctr[i] = 1;
      return;
    end
    if (!rdy_in) return;
    if (inst_valid && rexp) begin
      last_acc = 1;
      e = '{default: 0};
      e.tag = act + 1;
      e.pc  = inst_addr;
      ix    = int'((inst_addr >> 2) % 64);
      e.pred = (op == O_BR) && (ctr[ix] >= 2);
      e.typ = (op == O_ST) ? 2'd1 : (op == O_BR) ? 2'd2 :
              !known ? 2'd3 : 2'd0;
      e.ready = (op inside {O_LUI, O_AUIPC, O_JAL, O_JALR}) || !known;
      e.care_rd = op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_LD, O_OPI, O_OP};
      e.rd = 5'((inst >> 7) & 32'h1f);
      e.care_val = op inside {O_LUI, O_AUIPC, O_JAL, O_JALR};
      if (op == O_LUI) e.value = inst & 32'hFFFFF000;
      if (op == O_AUIPC) e.value = inst_addr + (inst & 32'hFFFFF000);
      if (op == O_JAL || op == O_JALR) e.value = inst_addr + 4;
      e.is_br = (op == O_BR);
      e.alt = e.pred ? inst_addr + 4 : inst_addr + imm_b(inst);
      if (op == O_JAL) begin
        e.redir = 1; e.raddr = inst_addr + imm_j(inst);
      end
      if (op == O_JALR) begin
        e.redir = 1; e.raddr = (reg_val1 + imm_i(inst)) & ~32'h1;
      end
      if (e.pred) begin
        e.redir = 1; e.raddr = inst_addr + imm_b(inst);
      end
      mul = (op == O_OP) && ((inst >> 25) == 1);
      e.rsv = nrs;
      e.rst = 6'(32'(mul) * 32 + 32'(op == O_BR) * 16
                 + 32'(inst[30]) * 8 + 32'(f3));
      e.lsbv = nlsb;
      e.lt = 4'(32'(op == O_ST) * 8 + 32'(f3));
      e.lo = (op == O_ST) ? imm_s(inst)[11:0] : imm_i(inst)[11:0];
      e.u1 = op inside {O_OP, O_OPI, O_BR, O_LD, O_ST, O_JALR};
      e.care_r2 = op inside {O_OP, O_BR, O_ST, O_OPI};
      e.r1 = reg_val1;
      e.r2 = reg_val2;
      if (op == O_OPI)
        e.r2 = (f3 == 1 || f3 == 5) ? (inst >> 20) & 32'h1f : imm_i(inst);
      e.hd1 = e.u1 && reg_has_dep1;
      e.hd2 = (op inside {O_OP, O_BR, O_ST}) && reg_has_dep2;
      e.d1 = reg_dep1;
      e.d2 = reg_dep2;
      e.rid = rob_free_id;
      sb.push_back(e);
    end
    if (bht_upd_valid) begin
      ix = int'((bht_upd_pc >> 2) % 64);
      if (bht_upd_taken) ctr[ix] = (ctr[ix] == 3) ? 3 : ctr[ix] + 1;
      else ctr[ix] = (ctr[ix] == 0) ? 0 : ctr[ix] - 1;
    end
  endtask

  always @(posedge clk_in) begin
    fresh = rdy_in && !rst_in;
    if (fresh) act++;
  end

  always @(negedge clk_in) begin
    if (fresh) begin
      if (rob_valid) begin
        if (sb.size() == 0) fail_one("unexpected_rob_valid");
        else begin
          m = sb.pop_front();
          chk("latency", 32'(act), 32'(m.tag));
          chk("rob_type", 32'(rob_type), 32'(m.typ));
          chk("rob_pc", rob_pc, m.pc);
          chk("rob_ready", 32'(rob_ready), 32'(m.ready));
          chk("rs_valid", 32'(rs_valid), 32'(m.rsv));
          chk("lsb_valid", 32'(lsb_valid), 32'(m.lsbv));
          chk("if_redirect", 32'(if_redirect), 32'(m.redir));
          chk("op_has_dep1", 32'(op_has_dep1), 32'(m.hd1));
          chk("op_has_dep2", 32'(op_has_dep2), 32'(m.hd2));
          chk("op_rob_id", 32'(op_rob_id), 32'(m.rid));
          if (m.care_rd) chk("rob_rd", 32'(rob_rd), 32'(m.rd));
          if (m.care_val) chk("rob_value", rob_value, m.value);
          if (m.is_br) begin
            chk("rob_alt_addr", rob_alt_addr, m.alt);
            chk("rob_pred_taken", 32'(rob_pred_taken), 32'(m.pred));
          end
          if (m.redir) chk("redirect_addr", if_redirect_addr, m.raddr);
          if (m.rsv) chk("rs_type", 32'(rs_type), 32'(m.rst));
          if (m.lsbv) begin
            chk("lsb_type", 32'(lsb_type), 32'(m.lt));
            chk("lsb_offset", 32'(lsb_offset), 32'(m.lo));
          end
          if (m.u1) chk("op_r1", op_r1, m.r1);
          if (m.care_r2) chk("op_r2", op_r2, m.r2);
          if (m.hd1) chk("op_dep1", 32'(op_dep1), 32'(m.d1));
          if (m.hd2) chk("op_dep2", 32'(op_dep2), 32'(m.d2));
        end
      end else begin
        if (rs_valid || lsb_valid || if_redirect)
          fail_one("valid_without_rob_valid");
        if (sb.size() != 0 && sb[0].tag <= act) begin
          fail_one("missing_output");
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk_in);
    model_eval();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rand_side();
    rob_full      = ($urandom % 10) == 0;
    rs_full       = ($urandom % 6) == 0;
    lsb_full      = ($urandom % 6) == 0;
    flush         = ($urandom % 15) == 0;
    rdy_in        = ($urandom % 8) != 0;
    bht_upd_valid = ($urandom % 3) == 0;
    bht_upd_pc    = 32'($urandom_range(0, 31)) * 4;
    bht_upd_taken = 1'($urandom % 2);
    reg_val1      = $urandom;
    reg_val2      = $urandom;
    reg_has_dep1  = ($urandom % 3) == 0;
    reg_has_dep2  = ($urandom % 3) == 0;
    reg_dep1      = 3'($urandom);
    reg_dep2      = 3'($urandom);
    rob_free_id   = 3'($urandom);
  endtask

  task automatic quiet_side();
    rob_full = 0; rs_full = 0; lsb_full = 0; flush = 0; rdy_in = 1;
    bht_upd_valid = 0; bht_upd_pc = 0; bht_upd_taken = 0;
    reg_val1 = 0; reg_val2 = 0; reg_has_dep1 = 0; reg_has_dep2 = 0;
    reg_dep1 = 0; reg_dep2 = 0; rob_free_id = 0;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc,
                       input bit rnd);
    int n;
    n = 0;
    inst = i;
    inst_addr = pc;
    inst_valid = 1;
    do begin
      if (rnd) rand_side();
      cycle();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) fail_one("offer_timeout");
    inst_valid = 0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: op = O_LUI;   1: op = O_AUIPC; 2: op = O_JAL;
      3: op = O_JALR;  4: op = O_BR;    5: op = O_LD;
      6: op = O_ST;    7: op = O_OPI;   8: op = O_OP;
      9: op = 7'b0001111;
      default: op = 7'b1110011;
    endcase
    r = {r[31:7], op};
    if (r == 32'hff9ff06f) r = r ^ 32'h80;
    return r;
  endfunction

  initial begin
    int cnt;
    quiet_side();
    inst = 0; inst_addr = 0; inst_valid = 0;
    rst_in = 1;
    repeat (2) cycle();
    chk("reset_rob_valid", 32'(rob_valid), 0);
    chk("reset_rs_valid", 32'(rs_valid), 0);
    chk("reset_lsb_valid", 32'(lsb_valid), 0);
    chk("reset_if_redirect", 32'(if_redirect), 0);
    chk("reset_rob_value", rob_value, 0);
    chk("reset_op_r2", op_r2, 0);
    rst_in = 0;

    offer(32'h00500093, 32'h0, 0);
    chk("addi_rob_valid", 32'(rob_valid), 1);
    chk("addi_rs_valid", 32'(rs_valid), 1);
    chk("addi_rob_rd", 32'(rob_rd), 1);
    chk("addi_op_r2", op_r2, 5);
    chk("addi_has_dep1", 32'(op_has_dep1), 0);
    chk("addi_rob_type", 32'(rob_type), 0);

    offer(32'h00000463, 32'h10, 0);
    chk("beq_nt_redirect", 32'(if_redirect), 0);
    chk("beq_nt_pred", 32'(rob_pred_taken), 0);
    chk("beq_nt_alt", rob_alt_addr, 32'h18);
    bht_upd_valid = 1; bht_upd_pc = 32'h10; bht_upd_taken = 1;
    repeat (3) cycle();
    bht_upd_valid = 0;
    offer(32'h00000463, 32'h10, 0);
    chk("beq_t_redirect", 32'(if_redirect), 1);
    chk("beq_t_addr", if_redirect_addr, 32'h18);
    chk("beq_t_alt", rob_alt_addr, 32'h14);

    reg_has_dep1 = 1;
    inst = 32'h003100E7; inst_addr = 32'h40; inst_valid = 1;
    repeat (3) begin
      cycle();
      chk("jalr_stall_ready", 32'(inst_ready), 0);
      chk("jalr_stall_valid", 32'(rob_valid), 0);
    end
    reg_has_dep1 = 0; reg_val1 = 32'h100;
    offer(32'h003100E7, 32'h40, 0);
    chk("jalr_redirect", 32'(if_redirect), 1);
    chk("jalr_addr", if_redirect_addr, 32'h102);
    chk("jalr_link", rob_value, 32'h44);

    lsb_full = 1;
    inst = 32'h00312223; inst_addr = 32'h50; inst_valid = 1;
    cnt = 0;
    repeat (2) begin cycle(); cnt += int'(lsb_valid); end
    lsb_full = 0;
    offer(32'h00312223, 32'h50, 0);
    cnt += int'(lsb_valid);
    chk("sw_lsb_type", 32'(lsb_type), 32'ha);
    chk("sw_rob_type", 32'(rob_type), 1);
    cycle();
    cnt += int'(lsb_valid);
    chk("sw_one_pulse", 32'(cnt), 1);

    bht_upd_valid = 1; bht_upd_pc = 32'h20; bht_upd_taken = 0;
    repeat (5) cycle();
    bht_upd_taken = 1;
    cycle();
    bht_upd_valid = 0;
    offer(32'h00000463, 32'h20, 0);
    chk("sat_low_pred", 32'(rob_pred_taken), 0);
    bht_upd_valid = 1; bht_upd_pc = 32'h20; bht_upd_taken = 1;
    offer(32'h00000463, 32'h20, 0);
    bht_upd_valid = 0;
    chk("same_cycle_pred", 32'(rob_pred_taken), 0);
    offer(32'h00000463, 32'h20, 0);
    chk("after_same_cycle_pred", 32'(rob_pred_taken), 1);

    flush = 1;
    inst = 32'h123452B7; inst_addr = 32'h60; inst_valid = 1;
    cycle();
    chk("flush_rob_valid", 32'(rob_valid), 0);
    flush = 0;
    offer(32'h123452B7, 32'h60, 0);
    chk("lui_value", rob_value, 32'h12345000);
    chk("lui_ready", 32'(rob_ready), 1);

    rdy_in = 0;
    inst = 32'h00500093; inst_addr = 32'h64; inst_valid = 1;
    bht_upd_valid = 1; bht_upd_pc = 32'h20; bht_upd_taken = 0;
    repeat (2) begin
      cycle();
      chk("freeze_valid", 32'(rob_valid), 1);
      chk("freeze_value", rob_value, 32'h12345000);
    end
    rdy_in = 1; bht_upd_valid = 0;
    offer(32'h00500093, 32'h64, 0);

    for (int k = 0; k < 300; k++) begin
      offer(gen_inst(), 32'($urandom_range(0, 31)) * 4, 1);
    end
    quiet_side();

    rst_in = 1;
    inst = 32'h00000463; inst_addr = 32'h10; inst_valid = 1;
    cycle();
    rst_in = 0; inst_valid = 0;
    chk("reset_drop_valid", 32'(rob_valid), 0);
    offer(32'h00000463, 32'h10, 0);
    chk("reset_bht_pred", 32'(rob_pred_taken), 0);

    repeat (3) cycle();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decoder_bp.md
Name: decoder_bp

Overview:
- Second-generation decode/dispatch stage for the RV32I out-of-order core.
- Sits between the instruction fetcher and the ROB, reservation station (RS) and load/store buffer (LSB).
- Replaces address-based duplicate suppression with a valid/ready handshake and handles ROB flush.
- Adds a parametrised BHT of 2-bit counters, so conditional branches get a real taken/not-taken prediction and a correct recovery address.

Parameters:
- ROB_W, 3, ROB index width in bits.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two; IDX = log2(BHT_ENTRIES).
- HALT_INST, 32'hff9ff06f, encoding dispatched as ROB type EX.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state and outputs
- flush  in  1  ROB misprediction flush
- inst_valid  in  1  fetcher offers an instruction
- inst_ready  out  1  decoder accepts the instruction (combinational)
- inst_addr, inst  in  32 each  PC and instruction word
- reg_id1, reg_id2  out  5 each  register file read indices (rs1, rs2 fields)
- reg_val1, reg_val2  in  32 each  register values
- reg_has_dep1, reg_has_dep2  in  1 each  register is renamed
- reg_dep1, reg_dep2  in  ROB_W each  producing ROB id
- rob_full  in  1; rob_free_id  in  ROB_W
- rob_valid  out  1; rob_type  out  2 (RG=0, ST=1, BR=2, EX=3); rob_rd  out  5
- rob_value, rob_pc, rob_alt_addr  out  32 each; rob_ready  out  1; rob_pred_taken  out  1
- rs_full  in  1; rs_valid  out  1; rs_type  out  6 = {mul, is_branch, inst[30], funct3}
- lsb_full  in  1; lsb_valid  out  1; lsb_type  out  4 = {is_store, funct3}; lsb_offset  out  12
- op_r1, op_r2  out  32 each; op_has_dep1, op_has_dep2  out  1 each; op_dep1, op_dep2  out  ROB_W each; op_rob_id  out  ROB_W
- bht_upd_valid  in  1; bht_upd_pc  in  32; bht_upd_taken  in  1  resolved-branch update from the ROB
- if_redirect  out  1; if_redirect_addr  out  32  fetch redirect

Behaviour:
- Reset values: all valid outputs and if_redirect are 0; every other registered output is 0; every BHT counter is 2'b01 (weakly not taken).
- inst_ready = !flush && !rob_full && !(needRS && rs_full) && !(needLSB && lsb_full) && !(JALR && reg_has_dep1).
  - needRS: opcodes BR, OP, OP-IMM.
  - needLSB: opcodes LOAD, STORE.
- Accept when inst_valid && inst_ready && rdy_in. The fetcher holds inst/inst_addr stable until accepted.
- All outputs are registered with 1-cycle latency. Each accepted instruction produces exactly one cycle of rob_valid, plus rs_valid or lsb_valid as applicable.
- A cycle with no accept drives all valids and if_redirect to 0 on the next edge.
- op_rob_id is registered from rob_free_id at accept.
- op_has_depN = (operand N used) && reg_has_depN.
- op_r2 selection:
  - OP-IMM: the sign-extended immI, or zero-extended shamt when funct3 is 001 or 101.
  - Otherwise reg_val2.
- rob_type: inst == HALT_INST → EX; STORE → ST; BR → BR; unknown opcode → EX with rob_ready=1; else RG.
- rob_ready = 1 for LUI, AUIPC, JAL, JALR.
- rob_value: LUI → immU<<12; AUIPC → pc + (immU<<12); JAL and JALR → pc+4.
- JAL: if_redirect=1, if_redirect_addr = pc + sext(immJ).
- JALR: if_redirect=1, if_redirect_addr = (reg_val1 + sext(immI)) & ~1.
- BR:
  - Prediction: ctr[pc[IDX+1:2]] >= 2.
  - Predicted taken: if_redirect=1 to pc + sext(immB); rob_alt_addr = pc+4.
  - Predicted not taken: no redirect; rob_alt_addr = pc + sext(immB).
  - rob_pred_taken carries the prediction.
- BHT update: on bht_upd_valid, the counter at bht_upd_pc[IDX+1:2] saturating-increments if taken, else saturating-decrements. It stays 3 on a taken update at 3 and stays 0 on a not-taken update at 0.
- A lookup and an update to the same index in the same cycle: the prediction uses the pre-update value, and the update still commits.
- flush:
  - Same cycle: no accept; next-edge valids and if_redirect are 0.
  - The BHT is not cleared.
  - An update arriving in the flush cycle still commits.
- rdy_in low: BHT, outputs and handshake all frozen; inst_ready is still driven but is ignored by the accept logic.
- Reset mid-stream: the pending output is dropped and the BHT is reinitialised.

Test Plan:
- Reset, then offer ADDI x1,x0,5 (0x00500093) at pc 0 → next cycle rob_valid=1, rs_valid=1, rob_rd=1, op_r2=5, op_has_dep1=0, rob_type=0.
- BEQ at pc 0x10 with offset +8 from reset state → no redirect, rob_pred_taken=0, rob_alt_addr=0x18. Then three bht_upd taken updates and the same BEQ again → if_redirect=1, addr 0x18, rob_alt_addr=0x14.
- JALR with reg_has_dep1=1 and inst_valid held → inst_ready=0 and no valids. Dependency clears with reg_val1=0x100 and imm=3 → redirect to 0x102.
- SW with lsb_full=1 for 2 cycles, then lsb_full=0 → exactly one lsb_valid pulse, lsb_type=4'b1010, rob_type=1.
- Four not-taken updates on a counter that is already at 0 → it stays 0. A same-cycle update and lookup on counter value 1 → prediction not taken, counter becomes 2.
- flush asserted with a valid LUI offered → no valids next cycle. LUI accepted the cycle after → rob_value = immU<<12, rob_ready=1.
